// File: rtl/y_mux_pkg.sv
// y_mux_pkg: project-wide constants for word-select muxes.
//   DATAPATH_WIDTH - width used for datapath word instances of y_mux.
//   SIZE_MIN/MAX   - legal range of the y_mux SIZE parameter.
package y_mux_pkg;

    localparam int unsigned DATAPATH_WIDTH = 32;
    localparam int unsigned SIZE_MIN       = 1;
    localparam int unsigned SIZE_MAX       = 64;

endpackage : y_mux_pkg

// File: rtl/y_mux_if.sv
// y_mux_if: bundle of the word-select data signals for connecting a y_mux.
//   a, b  - source words (a when c=0, b when c=1)
//   c     - select
//   z     - combinational result
//   q     - registered result
// Modports: master drives sources/select, slave drives results.
interface y_mux_if #(
    parameter int unsigned SIZE = 2
);

    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic            c;
    logic [SIZE-1:0] z;
    logic [SIZE-1:0] q;

    modport master (
        output a,
        output b,
        output c,
        input  z,
        input  q
    );

    modport slave (
        input  a,
        input  b,
        input  c,
        output z,
        output q
    );

endinterface : y_mux_if

// File: rtl/y_mux_bit.sv
// y_mux_bit: 1-bit gate-level 2-to-1 mux, z = (a & ~c) | (b & c).
//   z - output, a - source 0, b - source 1, c - select
module y_mux_bit (
    output wire z,
    input  wire a,
    input  wire b,
    input  wire c
);

    wire c_n;
    wire a_sel;
    wire b_sel;

    not u_not (c_n, c);
    and u_and_a (a_sel, a, c_n);
    and u_and_b (b_sel, b, c);
    or  u_or (z, a_sel, b_sel);

endmodule : y_mux_bit

// File: rtl/y_mux.sv
// y_mux: SIZE-bit 2-to-1 word-select mux with a registered copy of the result.
//   z   - combinational result, c ? b : a (independent of clk/rst)
//   a   - source 0
//   b   - source 1
//   c   - select, broadcast to every bit slice
//   clk - rising edge loads q from z
//   rst - async active-high, clears q
//   q   - z registered on clk
// Port order keeps legacy 4-port positional instances (z, a, b, c) valid.
module y_mux
    import y_mux_pkg::*;
#(
    parameter int unsigned SIZE = 2
) (
    output logic [SIZE-1:0] z,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            c,
    input  logic            clk,
    input  logic            rst,
    output logic [SIZE-1:0] q
);

    wire [SIZE-1:0] z_bits;

    // One gate-level slice per bit, all sharing the select.
    for (genvar i = 0; i < SIZE; i++) begin : g_bit
        y_mux_bit u_bit (
            .z (z_bits[i]),
            .a (a[i]),
            .b (b[i]),
            .c (c)
        );
    end

    assign z = z_bits;

    // Pipelined copy of the selected word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SIZE'(0);
        end else begin
            q <= z;
        end
    end

endmodule : y_mux

// File: tb/tb_y_mux.sv
// tb_y_mux: directed and swept checks of y_mux at SIZE=32, 1 and 2.
module tb_y_mux;
    import y_mux_pkg::*;

    localparam int unsigned W = DATAPATH_WIDTH;

    logic clk;
    logic rst;

    int vectors;
    int miscompares;

    y_mux_if #(.SIZE(W)) bus ();

    logic [0:0] a1, b1, z1, q1;
    logic       c1;
    logic [1:0] a2, b2, z2, q2;
    logic       c2;

    y_mux #(.SIZE(W)) u_dut32 (
        .z   (bus.z),
        .a   (bus.a),
        .b   (bus.b),
        .c   (bus.c),
        .clk (clk),
        .rst (rst),
        .q   (bus.q)
    );

    y_mux #(.SIZE(1)) u_dut1 (
        .z   (z1),
        .a   (a1),
        .b   (b1),
        .c   (c1),
        .clk (clk),
        .rst (rst),
        .q   (q1)
    );

    y_mux #(.SIZE(2)) u_dut2 (
        .z   (z2),
        .a   (a2),
        .b   (b2),
        .c   (c2),
        .clk (clk),
        .rst (rst),
        .q   (q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst   = 1'b1;
        bus.a = 32'h1111_2222;
        bus.b = 32'h3333_4444;
        bus.c = 1'b0;
        #1;
        vectors++;
        if (bus.q !== 32'h0) begin
            $display("FAIL reset_q32: got %h expected %h", bus.q, 32'h0);
            miscompares++;
        end
        vectors++;
        if (q1 !== 1'b0 || q2 !== 2'b00) begin
            $display("FAIL reset_q_small: got q1=%b q2=%b expected 0 0", q1, q2);
            miscompares++;
        end
        vectors++;
        if (bus.z !== 32'h1111_2222) begin
            $display("FAIL reset_z: got %h expected %h", bus.z, 32'h1111_2222);
            miscompares++;
        end
    endtask

    task automatic test_directed_select();
        bus.a = 32'h0000_0000;
        bus.b = 32'hFFFF_FFFF;
        bus.c = 1'b0;
        #1;
        vectors++;
        if (bus.z !== 32'h0000_0000) begin
            $display("FAIL select_c0: got %h expected %h", bus.z, 32'h0000_0000);
            miscompares++;
        end
        bus.c = 1'b1;
        #1;
        vectors++;
        if (bus.z !== 32'hFFFF_FFFF) begin
            $display("FAIL select_c1: got %h expected %h", bus.z, 32'hFFFF_FFFF);
            miscompares++;
        end
    endtask

    task automatic test_bit_independence();
        logic [W-1:0] exp_c0;
        logic [W-1:0] exp_c1;
        exp_c0 = 32'hAAAA_AAAA;
        exp_c1 = 32'h5555_5555;
        bus.a = 32'hAAAA_AAAA;
        bus.b = 32'h5555_5555;
        bus.c = 1'b0;
        #1;
        for (int i = 0; i < int'(W); i++) begin
            vectors++;
            if (bus.z[i] !== exp_c0[i]) begin
                $display("FAIL bits_c0[%0d]: got %b expected %b", i, bus.z[i], exp_c0[i]);
                miscompares++;
            end
        end
        bus.c = 1'b1;
        #1;
        for (int i = 0; i < int'(W); i++) begin
            vectors++;
            if (bus.z[i] !== exp_c1[i]) begin
                $display("FAIL bits_c1[%0d]: got %b expected %b", i, bus.z[i], exp_c1[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_equal_inputs();
        bus.a = 32'h1234_5678;
        bus.b = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            bus.c = k[0];
            #1;
            vectors++;
            if (bus.z !== 32'h1234_5678) begin
                $display("FAIL equal_c%0d: got %h expected %h", k[0], bus.z, 32'h1234_5678);
                miscompares++;
            end
        end
    endtask

    task automatic test_random_sweep();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W-1:0] exp;
        for (int n = 0; n < 500; n++) begin
            ra  = $urandom;
            rb  = $urandom;
            rc  = 1'($urandom % 2);
            exp = rc ? rb : ra;
            bus.a = ra;
            bus.b = rb;
            bus.c = rc;
            #1;
            vectors++;
            if (bus.z !== exp) begin
                $display("FAIL sweep_%0d: a=%b b=%b c=%b z=%b expected %b",
                         n, ra, rb, rc, bus.z, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_register_path();
        rst = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.q !== 32'h0) begin
            $display("FAIL reg_hold_reset: got %h expected %h", bus.q, 32'h0);
            miscompares++;
        end
        rst   = 1'b0;
        bus.a = 32'h0BAD_F00D;
        bus.b = 32'hDEAD_BEEF;
        bus.c = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.q !== 32'hDEAD_BEEF) begin
            $display("FAIL reg_load: got %h expected %h", bus.q, 32'hDEAD_BEEF);
            miscompares++;
        end
        bus.c = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.q !== 32'h0BAD_F00D) begin
            $display("FAIL reg_follow: got %h expected %h", bus.q, 32'h0BAD_F00D);
            miscompares++;
        end
        bus.c = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.q !== 32'h0) begin
            $display("FAIL reg_async_clear: got %h expected %h", bus.q, 32'h0);
            miscompares++;
        end
        vectors++;
        if (bus.z !== 32'hDEAD_BEEF) begin
            $display("FAIL reg_z_during_reset: got %h expected %h", bus.z, 32'hDEAD_BEEF);
            miscompares++;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.q !== 32'h0) begin
            $display("FAIL reg_hold_on_edge: got %h expected %h", bus.q, 32'h0);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.q !== 32'hDEAD_BEEF) begin
            $display("FAIL reg_first_after_release: got %h expected %h", bus.q, 32'hDEAD_BEEF);
            miscompares++;
        end
    endtask

    task automatic test_exhaustive_small();
        logic [2:0] v3;
        logic [4:0] v5;
        logic [0:0] e1;
        logic [1:0] e2;
        for (int v = 0; v < 8; v++) begin
            v3 = 3'(v);
            a1 = v3[2:2];
            b1 = v3[1:1];
            c1 = v3[0];
            e1 = c1 ? b1 : a1;
            #1;
            vectors++;
            if (z1 !== e1) begin
                $display("FAIL w1_%0d: a=%b b=%b c=%b z=%b expected %b", v, a1, b1, c1, z1, e1);
                miscompares++;
            end
        end
        for (int v = 0; v < 32; v++) begin
            v5 = 5'(v);
            a2 = v5[4:3];
            b2 = v5[2:1];
            c2 = v5[0];
            e2 = c2 ? b2 : a2;
            #1;
            vectors++;
            if (z2 !== e2) begin
                $display("FAIL w2_%0d: a=%b b=%b c=%b z=%b expected %b", v, a2, b2, c2, z2, e2);
                miscompares++;
            end
        end
        // Last vectors: a1=1,b1=1,c1=1 -> 1; a2=3,b2=3,c2=1 -> 3.
        @(posedge clk);
        #1;
        vectors++;
        if (q1 !== 1'b1 || q2 !== 2'b11) begin
            $display("FAIL small_q: got q1=%b q2=%b expected 1 11", q1, q2);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        a1 = '0; b1 = '0; c1 = 1'b0;
        a2 = '0; b2 = '0; c2 = 1'b0;
        test_reset();
        test_directed_select();
        test_bit_independence();
        test_equal_inputs();
        test_random_sweep();
        test_register_path();
        test_exhaustive_small();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_y_mux
